// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: rising-edge capture into a pending vector,
// fixed lowest-index priority, and a registered request/ack handshake to the core.
module ext_irq_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int IDW     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_sync,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               irq_ack,
  output logic               irq_req,
  output logic [IDW-1:0]     irq_id,
  output logic [NUM_IRQ-1:0] irq_pending
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [IDW-1:0]     id_next;
  logic [NUM_IRQ-1:0] prev;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] eligible;

  // Highest index is visited first so the lowest set index is the one left standing.
  function automatic logic [IDW-1:0] lowest_idx(input logic [NUM_IRQ-1:0] vec);
    logic [IDW-1:0] idx;
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDW'(i);
    end
    return idx;
  endfunction

  assign rise     = irq_sync & ~prev;
  assign eligible = irq_pending & irq_en;

  // Only an ack of the request actually being presented clears its line.
  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      clr[i] = (state == REQ) && irq_ack && (irq_id == IDW'(i));
    end
  end

  always_comb begin
    state_next = state;
    id_next    = irq_id;
    case (state)
      IDLE: begin
        if (|eligible) begin
          state_next = REQ;
          id_next    = lowest_idx(eligible);
        end
      end
      REQ: begin
        if (irq_ack) state_next = GAP;
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // prev resets high so lines already asserted at reset release raise no event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      irq_req     <= 1'b0;
      irq_id      <= '0;
      irq_pending <= '0;
      prev        <= '1;
    end else begin
      state       <= state_next;
      irq_req     <= (state_next == REQ);
      irq_id      <= id_next;
      irq_pending <= rise | (irq_pending & ~clr);
      prev        <= irq_sync;
    end
  end

endmodule
